mips_multicycle_core: RTL
=========================

# mips_multicycle_core

Multi-cycle MIPS-subset processor core, the successor to the single-cycle datapath. A state machine sequences each instruction over 3–5 cycles. All instruction and data accesses share one memory port with a ready handshake, so the core can sit in front of wait-stated or shared memory. Register-file writes, retirement and illegal opcodes are exposed for the bench and for the SoC wrapper.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NREGS`, default 32: number of architectural registers. Must be a power of two, at most 32. Register index bits above log2(NREGS) are ignored.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write enable; valid while `mem_req` is high.
- `mem_addr` out 32: byte address; bits [1:0] are always 0.
- `mem_wdata` out 32: store data.
- `mem_rdata` in 32: read data; valid in the cycle `mem_ready` is high.
- `mem_ready` in 1: access completes in the cycle `mem_req && mem_ready`.
- `Result` out 32: data written to the register file; holds its last value.
- `reg_we` out 1: pulses for the cycle in which a register-file write occurs.
- `retire` out 1: pulses for one cycle as each instruction completes.
- `illegal` out 1: pulses for one cycle on decode of an unsupported opcode or funct.

## Operation

- Supported instructions:
  - R-type (op 0x00): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
- Register r0 reads as 0; writes to r0 are discarded. `reg_we` still pulses on a write to r0.
- Internal registers: PC, IR, MDR, A, B, ALUOut. The ALU is 32-bit wrapping; slt is a signed compare and yields 0 or 1.
- FSM states and transitions:
  - FETCH: `mem_req=1`, `mem_we=0`, `mem_addr=PC`. Stay in FETCH until `mem_ready`. On ready: IR←rdata, PC←PC+4, go to DECODE.
  - DECODE: A←rf[rs], B←rf[rt], ALUOut←PC+(signext(imm)<<2). Branch on opcode to MEMADR (lw/sw), EXEC (R-type), ADDIEX, BRANCH or JUMP. An unsupported opcode or funct pulses `illegal` and `retire` and returns to FETCH as a NOP.
  - MEMADR: ALUOut←A+signext(imm); go to MEMRD or MEMWR.
  - MEMRD: request a read at ALUOut and wait for ready. On ready: MDR←rdata, go to MEMWB.
  - MEMWB: rf[rt]←MDR; retire.
  - MEMWR: request a write at ALUOut with `mem_wdata=B` and wait for ready. On ready: retire.
  - EXEC: ALUOut←A op B, then go to ALUWB, which writes rf[rd] and retires.
  - ADDIEX: ALUOut←A+signext(imm), then go to ADDIWB, which writes rf[rt] and retires.
  - BRANCH: if A==B then PC←ALUOut; retire.
  - JUMP: PC←{PC[31:28], IR[25:0], 2'b00}; retire.
  - Every retiring state returns to FETCH.
- Memory handshake rules:
  - While waiting for `mem_ready`, `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` hold stable.
  - `mem_req` is 0 in every other state.
  - A store completes exactly once.
- Effective addresses with bits [1:0] ≠ 0 are masked to word alignment.

## Timing

- Cycle counts with zero wait states: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3, illegal 2. Each wait cycle on a memory state adds 1.
- Register-file writes land at the end of the writeback cycle and are readable in the next DECODE.
- Reset values: PC=RESET_PC; state FETCH; all registers, IR, MDR, A, B, ALUOut = 0; `Result`=0; `mem_req`, `mem_we`, `reg_we`, `retire`, `illegal` = 0.
- Reset mid-operation, including during a pending memory wait, abandons the instruction with no register or PC update. `mem_req` drops on the cycle after `rst` is sampled high.
- The first FETCH request appears on the first cycle after `rst` deasserts.

## Structure

- Shared package `mips_pkg`: opcode and funct constants, FSM state enum, ALU operation enum, `sign_extend` function.
- Sub-module `mips_mc_ctrl`: the FSM plus decode. It takes opcode, funct, zero and mem_ready, and outputs mux selects, register enables and handshake strobes.
- The datapath and register file (NREGS × 32, 2 read ports, 1 write port) stay in the top module.

## Test plan

- Reset and first fetch: `rst` high 2 cycles, then low → `mem_req=1`, `mem_addr=RESET_PC` on the next cycle. All strobes 0 during reset.
- ALU sequence: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1; sub r5,r2,r1 → `Result` sequence 5, 0xFFFFFFFD, 2, 1, 0xFFFFFFF8; each R-type retires 4 cycles after its fetch.
- Memory with wait states: sw r1,8(r0) with `mem_ready` delayed 3 cycles → exactly one write to address 8 with data 5, and address/data stable throughout the wait. Then lw r6,8(r0) → `Result`=5 after 5+waits cycles.
- Control flow: beq r1,r1,+2 at PC 0x10 → next fetch at 0x1C; beq not taken → next fetch at 0x14. j 0x40 at 0x20 → next fetch at 0x100.
- Edge cases: addi r0,r0,7 → `reg_we` pulses, r0 still reads 0. Opcode 0x3F → `illegal` pulse, no write, next fetch at PC+4.
- Reset mid-wait: assert `rst` during the MEMWR wait → no memory write completes, PC=RESET_PC, and fetch restarts.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: opcodes, functs,
// FSM states, ALU operations and datapath mux encodings.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
  } state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
  typedef enum logic [1:0] {SRCB_REG, SRCB_IMM, SRCB_IMM_SH2} srcb_t;
  typedef enum logic [1:0] {PC_SRC_PLUS4, PC_SRC_ALUOUT, PC_SRC_JUMP} pc_src_t;

  function automatic logic [31:0] sign_extend(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_multicycle_core_if.sv
// Shared instruction/data memory port of the multi-cycle core.
interface mips_multicycle_core_if;
  // A transfer completes in the cycle mem_req && mem_ready; until then the
  // master holds mem_req, mem_we, mem_addr and mem_wdata stable. mem_rdata is
  // valid only in the completing cycle.
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/mips_mc_ctrl.sv
// Sequencer and decoder for the multi-cycle core. Memory strobes are registered
// from the next state; datapath enables decode the current state.
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic    zero,
  input  logic    mem_ready,
  output state_t  state,
  output logic    mem_req,
  output logic    mem_we,
  output logic    iord,
  output logic    ir_we,
  output logic    pc_we,
  output pc_src_t pc_src,
  output logic    ab_we,
  output logic    aluout_we,
  output logic    alu_a_pc,
  output srcb_t   alu_srcb,
  output alu_op_t alu_op,
  output logic    mdr_we,
  output logic    reg_we,
  output logic    reg_dst_rd,
  output logic    retire,
  output logic    illegal
);

  state_t  state_n;
  alu_op_t rtype_op;
  logic    funct_ok;
  logic    decode_bad;
  logic    hs;

  assign hs = mem_req && mem_ready;

  always_comb begin
    funct_ok = 1'b1;
    rtype_op = ALU_ADD;
    case (funct)
      FN_ADD:  rtype_op = ALU_ADD;
      FN_SUB:  rtype_op = ALU_SUB;
      FN_AND:  rtype_op = ALU_AND;
      FN_OR:   rtype_op = ALU_OR;
      FN_SLT:  rtype_op = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
    case (opcode)
      OP_RTYPE:                          decode_bad = !funct_ok;
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: decode_bad = 1'b0;
      default:                           decode_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_n    = state;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_SRC_PLUS4;
    ab_we      = 1'b0;
    aluout_we  = 1'b0;
    alu_a_pc   = 1'b0;
    alu_srcb   = SRCB_REG;
    alu_op     = ALU_ADD;
    mdr_we     = 1'b0;
    reg_we     = 1'b0;
    reg_dst_rd = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: if (hs) begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        state_n = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the ALU is otherwise idle.
        ab_we     = 1'b1;
        aluout_we = 1'b1;
        alu_a_pc  = 1'b1;
        alu_srcb  = SRCB_IMM_SH2;
        if (decode_bad) begin
          illegal = 1'b1;
          retire  = 1'b1;
          state_n = S_FETCH;
        end else begin
          case (opcode)
            OP_LW, OP_SW: state_n = S_MEMADR;
            OP_RTYPE:     state_n = S_EXEC;
            OP_ADDI:      state_n = S_ADDIEX;
            OP_BEQ:       state_n = S_BRANCH;
            default:      state_n = S_JUMP;
          endcase
        end
      end
      S_MEMADR: begin
        aluout_we = 1'b1;
        alu_srcb  = SRCB_IMM;
        state_n   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (hs) begin
          mdr_we  = 1'b1;
          state_n = S_MEMWB;
        end
      end
      S_MEMWB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_MEMWR: begin
        iord = 1'b1;
        if (hs) begin
          retire  = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_EXEC: begin
        aluout_we = 1'b1;
        alu_op    = rtype_op;
        state_n   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we     = 1'b1;
        reg_dst_rd = 1'b1;
        retire     = 1'b1;
        state_n    = S_FETCH;
      end
      S_ADDIEX: begin
        aluout_we = 1'b1;
        alu_srcb  = SRCB_IMM;
        state_n   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_BRANCH: begin
        alu_op  = ALU_SUB;
        pc_we   = zero;
        pc_src  = PC_SRC_ALUOUT;
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_JUMP: begin
        pc_we   = 1'b1;
        pc_src  = PC_SRC_JUMP;
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
    if (rst) begin
      reg_we  = 1'b0;
      retire  = 1'b0;
      illegal = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end else begin
      state   <= state_n;
      mem_req <= (state_n == S_FETCH) || (state_n == S_MEMRD) || (state_n == S_MEMWR);
      mem_we  <= (state_n == S_MEMWR);
    end
  end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: datapath and register file around mips_mc_ctrl,
// with all instruction and data traffic on one ready-handshaked memory port.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  mips_multicycle_core_if.master mem,
  output logic [31:0]            Result,
  output logic                   reg_we,
  output logic                   retire,
  output logic                   illegal
);

  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [31:0] pc, ir, mdr, a, b, alu_out, result_q;
  logic [31:0] rf [NREGS];

  state_t  state;
  logic    req, we, iord, ir_we, pc_we, ab_we, aluout_we, alu_a_pc, mdr_we, reg_dst_rd;
  pc_src_t pc_src;
  srcb_t   alu_srcb;
  alu_op_t alu_op;

  logic [RW-1:0] rs_idx, rt_idx, rd_idx, wr_idx;
  logic [31:0]   imm_ext, src_a, src_b, alu_y, wb_data, addr;
  logic          zero;

  assign rs_idx  = ir[21 +: RW];
  assign rt_idx  = ir[16 +: RW];
  assign rd_idx  = ir[11 +: RW];
  assign wr_idx  = reg_dst_rd ? rd_idx : rt_idx;
  assign imm_ext = sign_extend(ir[15:0]);

  mips_mc_ctrl u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .opcode     (ir[31:26]),
    .funct      (ir[5:0]),
    .zero       (zero),
    .mem_ready  (mem.mem_ready),
    .state      (state),
    .mem_req    (req),
    .mem_we     (we),
    .iord       (iord),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .ab_we      (ab_we),
    .aluout_we  (aluout_we),
    .alu_a_pc   (alu_a_pc),
    .alu_srcb   (alu_srcb),
    .alu_op     (alu_op),
    .mdr_we     (mdr_we),
    .reg_we     (reg_we),
    .reg_dst_rd (reg_dst_rd),
    .retire     (retire),
    .illegal    (illegal)
  );

  // Low address bits are dropped so misaligned effective addresses hit the word.
  assign addr          = iord ? alu_out : pc;
  assign mem.mem_req   = req;
  assign mem.mem_we    = we;
  assign mem.mem_addr  = {addr[31:2], 2'b00};
  assign mem.mem_wdata = b;

  always_comb begin
    src_a = alu_a_pc ? pc : a;
    case (alu_srcb)
      SRCB_IMM:     src_b = imm_ext;
      SRCB_IMM_SH2: src_b = {imm_ext[29:0], 2'b00};
      default:      src_b = b;
    endcase
    case (alu_op)
      ALU_SUB: alu_y = src_a - src_b;
      ALU_AND: alu_y = src_a & src_b;
      ALU_OR:  alu_y = src_a | src_b;
      ALU_SLT: alu_y = {31'd0, ($signed(src_a) < $signed(src_b))};
      default: alu_y = src_a + src_b;
    endcase
  end

  assign zero    = (alu_y == 32'd0);
  assign wb_data = (state == S_MEMWB) ? mdr : alu_out;
  assign Result  = reg_we ? wb_data : result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      ir       <= '0;
      mdr      <= '0;
      a        <= '0;
      b        <= '0;
      alu_out  <= '0;
      result_q <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      if (ir_we) ir <= mem.mem_rdata;
      if (pc_we) begin
        case (pc_src)
          PC_SRC_ALUOUT: pc <= alu_out;
          PC_SRC_JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
          default:       pc <= pc + 32'd4;
        endcase
      end
      if (ab_we) begin
        a <= rf[rs_idx];
        b <= rf[rt_idx];
      end
      if (aluout_we) alu_out <= alu_y;
      if (mdr_we) mdr <= mem.mem_rdata;
      // r0 stays zero because index 0 is never written.
      if (reg_we) begin
        result_q <= wb_data;
        if (wr_idx != '0) rf[wr_idx] <= wb_data;
      end
    end
  end

endmodule
